// File: rtl/snail_pkg.sv
// rtl/snail_pkg.sv - shared definitions for the snail serial link
// Purpose: state encodings, idle line level and the length-field width helper
//          used by the pattern transmitter and the detector-side bench.
// Ports:   none (package).
package snail_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } snail_state_t;

  // Level driven on the serial line whenever no pattern bit is being sent.
  localparam logic IDLE_LEVEL = 1'b1;

  // Width of a length field able to hold the values 0..width inclusive.
  function automatic int snail_len_w(input int width);
    return $clog2(width + 1);
  endfunction

  localparam int SNAIL_DEF_WIDTH = 8;
  localparam int SNAIL_DEF_LEN_W = $clog2(SNAIL_DEF_WIDTH + 1);

endpackage

// File: rtl/snail_down_counter.sv
// rtl/snail_down_counter.sv - loadable down-counter with zero flag
// Purpose: holds a count that can be loaded or decremented by one; reports zero.
// Ports:   clk, rst (async, active-high), load/load_val (load wins over dec),
//          dec (decrement by one), count (current value), zero (count == 0).
module snail_down_counter
  import snail_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/snail_seq_gen.sv
// rtl/snail_seq_gen.sv - serial bit-pattern transmitter, MSB first
// Purpose: shifts pattern[len-1:0] onto sd_out one bit per clock, repeats it
//          reps times with GAP_BITS idle-level bits between repetitions.
// Ports:   clk, rst (async, active-high); start, abort, pattern, len, reps in;
//          sd_out (serial line, idle 1), sd_valid (bit present), busy,
//          done (one-cycle pulse after normal completion) out; all registered.
module snail_seq_gen
  import snail_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int GAP_BITS = 2,
  parameter int REP_W    = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         abort,
  input  logic [WIDTH-1:0]             pattern,
  input  logic [$clog2(WIDTH+1)-1:0]   len,
  input  logic [REP_W-1:0]             reps,
  output logic                         sd_out,
  output logic                         sd_valid,
  output logic                         busy,
  output logic                         done
);

  localparam int LEN_W = snail_len_w(WIDTH);
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int GAP_W = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
  // The gap counter runs GAP_BITS-1 .. 0, one idle bit per count.
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

  snail_state_t       state, state_d;
  logic               sd_out_d, sd_valid_d, busy_d, done_d;

  logic [WIDTH-1:0]   pat_q;
  logic [LEN_W-1:0]   len_q;
  logic               capture;

  logic [LEN_W-1:0]   len_eff;
  logic [IDX_W-1:0]   idx_first_in;   // top bit index of the incoming request
  logic [IDX_W-1:0]   idx_first_q;    // top bit index of the captured request
  logic [IDX_W-1:0]   idx_minus1;

  logic               idx_load, idx_dec, idx_zero;
  logic [IDX_W-1:0]   idx_load_val, idx_count;
  logic               gap_load, gap_dec, gap_zero;
  logic [GAP_W-1:0]   gap_count_unused;
  logic               rep_load, rep_dec, rep_zero;
  logic [REP_W-1:0]   rep_load_val, rep_count_unused;

  assign len_eff      = (len > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : len;
  assign idx_first_in = IDX_W'(len_eff - LEN_W'(1));
  assign idx_first_q  = IDX_W'(len_q - LEN_W'(1));
  assign idx_minus1   = idx_count - IDX_W'(1);
  assign rep_load_val = (reps == '0) ? '0 : reps - REP_W'(1);

  snail_down_counter #(.W(IDX_W)) u_idx_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (idx_load),
    .load_val (idx_load_val),
    .dec      (idx_dec),
    .count    (idx_count),
    .zero     (idx_zero)
  );

  snail_down_counter #(.W(GAP_W)) u_gap_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (gap_load),
    .load_val (GAP_LOAD),
    .dec      (gap_dec),
    .count    (gap_count_unused),
    .zero     (gap_zero)
  );

  snail_down_counter #(.W(REP_W)) u_rep_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (rep_load),
    .load_val (rep_load_val),
    .dec      (rep_dec),
    .count    (rep_count_unused),
    .zero     (rep_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      sd_out   <= IDLE_LEVEL;
      sd_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pat_q    <= '0;
      len_q    <= '0;
    end else begin
      state    <= state_d;
      sd_out   <= sd_out_d;
      sd_valid <= sd_valid_d;
      busy     <= busy_d;
      done     <= done_d;
      if (capture) begin
        pat_q <= pattern;
        len_q <= len_eff;
      end
    end
  end

  // Outputs are computed one cycle ahead: sd_out_d is the bit that will be on
  // the line during the next cycle.
  always_comb begin
    state_d      = state;
    sd_out_d     = IDLE_LEVEL;
    sd_valid_d   = 1'b0;
    busy_d       = busy;
    done_d       = 1'b0;
    capture      = 1'b0;
    idx_load     = 1'b0;
    idx_load_val = idx_first_q;
    idx_dec      = 1'b0;
    gap_load     = 1'b0;
    gap_dec      = 1'b0;
    rep_load     = 1'b0;
    rep_dec      = 1'b0;

    case (state)
      IDLE: begin
        busy_d = 1'b0;
        if (start && !abort) begin
          capture  = 1'b1;
          rep_load = 1'b1;
          if (len_eff != '0) begin
            state_d      = SHIFT;
            idx_load     = 1'b1;
            idx_load_val = idx_first_in;
            sd_out_d     = pattern[idx_first_in];
            sd_valid_d   = 1'b1;
            busy_d       = 1'b1;
          end else begin
            // Empty request completes immediately without touching the line.
            done_d = 1'b1;
          end
        end
      end

      SHIFT: begin
        if (abort) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else if (!idx_zero) begin
          idx_dec    = 1'b1;
          sd_out_d   = pat_q[idx_minus1];
          sd_valid_d = 1'b1;
        end else if (!rep_zero) begin
          rep_dec = 1'b1;
          if (GAP_BITS > 0) begin
            state_d  = GAP;
            gap_load = 1'b1;
          end else begin
            // Back-to-back repetition: restart at the top bit with no bubble.
            idx_load   = 1'b1;
            sd_out_d   = pat_q[idx_first_q];
            sd_valid_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end

      GAP: begin
        if (abort) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else if (gap_zero) begin
          state_d    = SHIFT;
          idx_load   = 1'b1;
          sd_out_d   = pat_q[idx_first_q];
          sd_valid_d = 1'b1;
        end else begin
          gap_dec = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_snail_seq_gen.sv
// tb/tb_snail_seq_gen.sv - directed self-checking bench for snail_seq_gen
module tb_snail_seq_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       start2 = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] pattern = 8'h00;
  logic [3:0] len = 4'd0;
  logic [3:0] reps = 4'd0;

  logic sd_out, sd_valid, busy, done;
  logic sd_out2, sd_valid2, busy2, done2;

  int vectors = 0;
  int errs = 0;

  always #5 clk = ~clk;

  snail_seq_gen #(.WIDTH(8), .GAP_BITS(2), .REP_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .pattern(pattern),
    .len(len), .reps(reps), .sd_out(sd_out), .sd_valid(sd_valid),
    .busy(busy), .done(done)
  );

  snail_seq_gen #(.WIDTH(8), .GAP_BITS(0), .REP_W(4)) dut_b2b (
    .clk(clk), .rst(rst), .start(start2), .abort(abort), .pattern(pattern),
    .len(len), .reps(reps), .sd_out(sd_out2), .sd_valid(sd_valid2),
    .busy(busy2), .done(done2)
  );

  // Minimal 000 detector on the back-to-back line (non-overlapping runs).
  int det_cnt = 0;
  int det_hits = 0;
  always @(posedge clk) begin
    if (rst) begin
      det_cnt  <= 0;
      det_hits <= 0;
    end else if (sd_valid2 && !sd_out2) begin
      if (det_cnt == 2) begin
        det_cnt  <= 0;
        det_hits <= det_hits + 1;
      end else begin
        det_cnt <= det_cnt + 1;
      end
    end else begin
      det_cnt <= 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks nbits pattern bits (MSB of exp first) and the done cycle after them.
  task automatic expect_frame(input string tag, input logic [7:0] exp, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      chk({tag, "_valid"}, 32'(sd_valid), 32'd1);
      chk({tag, "_bit"}, 32'(sd_out), 32'(exp[nbits-1-i]));
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      chk({tag, "_nodone"}, 32'(done), 32'd0);
      tick();
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
    chk({tag, "_idle_valid"}, 32'(sd_valid), 32'd0);
    chk({tag, "_idle_out"}, 32'(sd_out), 32'd1);
    tick();
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  logic [12:0] seq_out, seq_val;
  int          done_seen;

  initial begin
    tick();
    tick();
    chk("rst_out", 32'(sd_out), 32'd1);
    chk("rst_valid", 32'(sd_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    tick();

    // 1: single transmission
    pattern = 8'b1000_1000; len = 4'd8; reps = 4'd1; start = 1'b1;
    tick();
    start = 1'b0;
    expect_frame("single", 8'b1000_1000, 8);

    // 2: three repetitions with two guard bits
    pattern = 8'h00; len = 4'd3; reps = 4'd3; start = 1'b1;
    tick();
    start = 1'b0;
    seq_out = 13'b000_11_000_11_000;
    seq_val = 13'b111_00_111_00_111;
    done_seen = 0;
    for (int i = 0; i < 13; i++) begin
      chk("gap_out", 32'(sd_out), 32'(seq_out[12-i]));
      chk("gap_valid", 32'(sd_valid), 32'(seq_val[12-i]));
      chk("gap_busy", 32'(busy), 32'd1);
      if (done) done_seen++;
      tick();
    end
    chk("gap_early_done", 32'(done_seen), 32'd0);
    chk("gap_done", 32'(done), 32'd1);
    tick();
    chk("gap_done_pulse", 32'(done), 32'd0);

    // 3: zero length, then length clamp
    pattern = 8'hFF; len = 4'd0; reps = 4'd1; start = 1'b1;
    tick();
    start = 1'b0;
    chk("len0_done", 32'(done), 32'd1);
    chk("len0_busy", 32'(busy), 32'd0);
    chk("len0_valid", 32'(sd_valid), 32'd0);
    tick();
    chk("len0_pulse", 32'(done), 32'd0);
    chk("len0_valid2", 32'(sd_valid), 32'd0);
    pattern = 8'hA5; len = 4'd12; reps = 4'd1; start = 1'b1;
    tick();
    start = 1'b0;
    expect_frame("clamp", 8'b1010_0101, 8);

    // 4: abort during bit 4, then abort blocking a start in IDLE
    pattern = 8'hFF; len = 4'd8; reps = 4'd2; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    chk("abort_pre_valid", 32'(sd_valid), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_out", 32'(sd_out), 32'd1);
    chk("abort_valid", 32'(sd_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    tick();
    chk("abort_done2", 32'(done), 32'd0);
    chk("abort_stays_idle", 32'(busy), 32'd0);
    abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    chk("abort_blk_busy", 32'(busy), 32'd0);
    chk("abort_blk_valid", 32'(sd_valid), 32'd0);
    chk("abort_blk_done", 32'(done), 32'd0);

    // 5a: start while busy with changed inputs is ignored
    pattern = 8'b1000_1000; len = 4'd8; reps = 4'd1; start = 1'b1;
    tick();
    pattern = 8'h77; len = 4'd5; reps = 4'd4;
    tick();
    tick();
    start = 1'b0;
    seq_out = 13'd0;
    seq_out[7:0] = 8'b1000_1000;
    for (int i = 2; i < 8; i++) begin
      chk("busy_bit", 32'(sd_out), 32'(seq_out[7-i]));
      chk("busy_valid", 32'(sd_valid), 32'd1);
      tick();
    end
    chk("busy_done", 32'(done), 32'd1);
    tick();

    // 5b: reset during a gap
    pattern = 8'h00; len = 4'd3; reps = 4'd3; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    chk("rgap_valid", 32'(sd_valid), 32'd0);
    chk("rgap_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("rgap_out", 32'(sd_out), 32'd1);
    chk("rgap_busy0", 32'(busy), 32'd0);
    chk("rgap_done", 32'(done), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("rgap_after_done", 32'(done), 32'd0);
    chk("rgap_after_valid", 32'(sd_valid), 32'd0);

    // 6: back-to-back repetitions into the 000 detector, restart in done cycle
    pattern = 8'h00; len = 4'd3; reps = 4'd2; start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("b2b_out", 32'(sd_out2), 32'd0);
      chk("b2b_valid", 32'(sd_valid2), 32'd1);
      tick();
    end
    chk("b2b_done", 32'(done2), 32'd1);
    chk("b2b_det_hits", 32'(det_hits), 32'd2);
    pattern = 8'h01; len = 4'd1; reps = 4'd1; start2 = 1'b1;
    tick();
    start2 = 1'b0;
    chk("b2b_restart_out", 32'(sd_out2), 32'd1);
    chk("b2b_restart_valid", 32'(sd_valid2), 32'd1);
    chk("b2b_restart_busy", 32'(busy2), 32'd1);
    tick();
    chk("b2b_restart_done", 32'(done2), 32'd1);
    tick();
    chk("b2b_final_idle", 32'(busy2), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/snail_seq_gen.md
Name: snail_seq_gen

Overview:
Serial bit-pattern transmitter. It shifts a programmable bit pattern, MSB-first, onto a single serial line, one bit per clock. This is the stimulus/driver end of the serial sequence-detector link, and its sd_out feeds a detector's D input directly. It supports repeated transmissions separated by idle-level guard bits, and an abort.

Parameters:
WIDTH, 8, maximum pattern length in bits
GAP_BITS, 2, idle-level (1) bits inserted between repetitions; 0 = back-to-back
REP_W, 4, width of the repetition-count input

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
start  input  1  request a transmission; sampled only while busy=0
abort  input  1  synchronous cancel of the current transmission
pattern  input  WIDTH  bits to send; the active field is pattern[len-1:0]
len  input  $clog2(WIDTH+1)  number of bits per transmission
reps  input  REP_W  total number of transmissions; 0 is treated as 1
sd_out  output  1  serial data line, registered; idle level 1
sd_valid  output  1  registered; high while sd_out carries a pattern bit
busy  output  1  registered; high from the accepting edge through the last bit
done  output  1  registered single-cycle pulse after normal completion

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous, active-high.
- Reset values: state=IDLE, sd_out=1, sd_valid=0, busy=0, done=0, all counters 0. A reset asserted mid-transmission returns the block to IDLE immediately; no done pulse is produced.
- States: IDLE, SHIFT, GAP.
- IDLE:
  - On an edge with start=1 and abort=0, capture pattern, len_eff=min(len,WIDTH), and rep_left=max(reps,1)-1.
  - If len_eff>0: enter SHIFT. On that same edge drive sd_out=pattern[len_eff-1], sd_valid=1, busy=1. Latency is one cycle: the first bit is visible in the cycle after start is sampled.
  - If len_eff=0: stay in IDLE, set done=1 for one cycle, keep busy=0, emit no bits.
- SHIFT: bit index decrements each edge, and sd_out presents the pattern bits from len_eff-1 down to 0. After bit 0 has been presented for one cycle:
  - rep_left>0 and GAP_BITS>0: enter GAP, sd_out=1, sd_valid=0, decrement rep_left.
  - rep_left>0 and GAP_BITS=0: reload the index to len_eff-1, present pattern[len_eff-1] on the next cycle with no bubble, decrement rep_left.
  - rep_left=0: enter IDLE, sd_out=1, sd_valid=0, busy=0, done=1 for exactly one cycle.
- GAP: hold sd_out=1, sd_valid=0 for exactly GAP_BITS cycles. Then enter SHIFT with sd_out=pattern[len_eff-1], sd_valid=1.
- busy stays 1 throughout SHIFT and GAP.
- abort=1 in SHIFT or GAP: next edge goes to IDLE with sd_out=1, sd_valid=0, busy=0, done=0.
- abort=1 in IDLE: no effect, and it blocks a same-cycle start (abort has priority).
- start while busy=1 is ignored; changes to pattern/len/reps while busy do not affect the transmission in flight.
- A new start sampled in the cycle in which done=1 is legal and accepted, with the same one-cycle latency.
- sd_out is never X and never 0 outside SHIFT, so an attached zero-run detector sees no spurious zeros while idle or in a gap.

Decomposition:
- Shared package snail_pkg holds:
  - state encodings IDLE=0, SHIFT=1, GAP=2 (2-bit);
  - IDLE_LEVEL=1'b1;
  - a length-width helper constant, shared with the detector-side bench.
- One natural sub-module: snail_down_counter, a loadable down-counter with a zero flag. It is instantiated for the bit index, the gap count and the repetition count.
- The FSM and output registers stay in snail_seq_gen.

Test Plan:
1. Single transmission: pattern=8'b1000_1000, len=8, reps=1 -> sd_out=1,0,0,0,1,0,0,0 with sd_valid=1 for 8 cycles starting the cycle after start; done pulse in cycle 9; busy low in cycle 9.
2. Repetitions with gap (GAP_BITS=2): pattern=3'b000, len=3, reps=3 -> sd_out=000 11 000 11 000 with sd_valid=0 on the gap bits; exactly one done pulse, after the last 0.
3. Zero length and clamp: len=0 -> done pulse one cycle later, sd_valid never high. len=12, pattern=8'hA5 -> 8 bits 10100101, then done.
4. Abort: start pattern=8'hFF, len=8, reps=2; assert abort during bit 4 -> next cycle sd_out=1, sd_valid=0, busy=0, no done pulse. A start sampled together with abort in IDLE is ignored.
5. Start while busy and reset mid-operation: a second start during SHIFT with a different pattern -> the original bits continue unchanged. Asserting rst during GAP -> outputs immediately take their reset values, no done pulse.
6. Back-to-back (GAP_BITS=0) with loopback to a 000 detector: pattern=3'b000, reps=2 -> six consecutive 0s, no bubble, detector output high on the 3rd and 6th bits per its own latency. Start sampled in the done cycle -> accepted, new first bit in the following cycle.
